// File: rtl/motor_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motor_master_pkg
// Brief    : Shared constants, FSM state type and helpers for motor_master.
// Revision : 1.0
// ============================================================================
package motor_master_pkg;

    localparam logic [3:0] c_TAG_OVF   = 4'hF;
    localparam logic [3:0] c_TAG_MAX   = 4'hE;
    localparam int         c_CNT_W     = 12;
    localparam int         c_ODO_W     = 32;
    localparam int         c_CMD_W     = 24;
    localparam int         c_DIR1_BIT  = 11;
    localparam int         c_DIR2_BIT  = 23;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    // Tags cycle 0..E; F is reserved for overflow reports.
    function automatic logic [3:0] next_tag(input logic [3:0] t);
        return (t == c_TAG_MAX) ? 4'h0 : t + 4'h1;
    endfunction

    function automatic logic [c_CMD_W-1:0] estop_cmd(input logic [c_CMD_W-1:0] c);
        return {c[c_DIR2_BIT], 11'd0, c[c_DIR1_BIT], 11'd0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_master_if.sv
`default_nettype none
// ============================================================================
// Module   : motor_master_if
// Brief    : Host command port plus motor command/report bus.
// Revision : 1.0
// ============================================================================
interface motor_master_if;
    import motor_master_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [c_CMD_W-1:0] cmd_data;
    logic [3:0]         m_ctrl;
    logic [c_CMD_W-1:0] m_data;
    logic               m_wr;
    logic [3:0]         r_ctrl;
    logic [c_CMD_W-1:0] r_data;
    logic               r_wr;

    modport master (
        input  cmd_valid, cmd_data, r_ctrl, r_data, r_wr,
        output cmd_ready, m_ctrl, m_data, m_wr
    );

    modport slave (
        output cmd_valid, cmd_data, r_ctrl, r_data, r_wr,
        input  cmd_ready, m_ctrl, m_data, m_wr
    );
endinterface
`default_nettype wire

// File: rtl/motor_master_odometer.sv
`default_nettype none
// ============================================================================
// Module   : motor_odometer
// Brief    : One channel's signed odometer driven by 12-bit wrapping counts.
// Revision : 1.0
// ============================================================================
module motor_odometer
    import motor_master_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [c_CNT_W-1:0] new_cnt,
    input  wire logic               is_ovf,
    input  wire logic               run_start,
    input  wire logic               clear_last,
    input  wire logic               dir,
    input  wire logic               update,
    output logic      [c_ODO_W-1:0] odo
);
    logic [c_CNT_W-1:0] r_last;
    logic [c_ODO_W-1:0] r_odo;
    logic [c_CNT_W:0]   w_delta;
    logic [c_ODO_W-1:0] w_step;

    always_comb begin
        w_delta = {1'b0, new_cnt - r_last};
        // A fresh overflow run that sees FFF again means the counter went all the way round.
        if (is_ovf && run_start && (&new_cnt) && (&r_last))
            w_delta = {1'b1, {c_CNT_W{1'b0}}};
        w_step = dir ? c_ODO_W'(w_delta) : -c_ODO_W'(w_delta);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
            r_odo  <= '0;
        end else if (update) begin
            r_odo  <= r_odo + w_step;
            r_last <= clear_last ? '0 : new_cnt;
        end
    end

    assign odo = r_odo;
endmodule
`default_nettype wire

// File: rtl/motor_master.sv
`default_nettype none
// ============================================================================
// Module   : motor_master
// Brief    : Tagged motor command initiator with report matching and odometers.
// Revision : 1.0
// ============================================================================
module motor_master
    import motor_master_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 1000000,
    parameter int unsigned TIMEOUT     = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    motor_master_if.master    bus,
    input  wire logic         estop,
    output logic [c_ODO_W-1:0] odo1,
    output logic [c_ODO_W-1:0] odo2,
    output logic              rsp_valid,
    output logic [c_CMD_W-1:0] rsp_counts,
    output logic              err_timeout,
    output logic              err_tag,
    output logic              busy
);
    localparam int c_PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int c_TW = $clog2(TIMEOUT + 1);

    state_t             r_state, w_state_n;
    logic [3:0]         r_tag;
    logic [c_CMD_W-1:0] r_issue_data, r_last_cmd, r_counts, w_load_data;
    logic [1:0]         r_prev_dir, w_dir;
    logic [c_PW-1:0]    r_poll;
    logic [c_TW-1:0]    r_wait;
    logic               r_prev_ovf, r_err_timeout, r_err_tag;
    logic               w_load, w_timeout, w_match, w_ovf, w_stray, w_poll_hit, w_wait_last;

    assign w_ovf       = bus.r_wr && (bus.r_ctrl == c_TAG_OVF);
    assign w_match     = (r_state == ST_WAIT_RSP) && bus.r_wr && (bus.r_ctrl == r_tag);
    assign w_stray     = bus.r_wr && !w_ovf && !w_match;
    assign w_poll_hit  = (POLL_CYCLES != 0) && (32'(r_poll) == POLL_CYCLES - 1);
    assign w_wait_last = (32'(r_wait) == TIMEOUT - 1);
    // Counts reported now were accumulated under the command in force before the latest issue.
    assign w_dir = (r_state == ST_ISSUE) ? {r_last_cmd[c_DIR2_BIT], r_last_cmd[c_DIR1_BIT]}
                                         : r_prev_dir;

    always_comb begin
        w_state_n   = r_state;
        w_load      = 1'b0;
        w_load_data = r_last_cmd;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (estop) begin
                    w_load      = 1'b1;
                    w_load_data = estop_cmd(r_last_cmd);
                end else if (bus.cmd_valid) begin
                    w_load      = 1'b1;
                    w_load_data = bus.cmd_data;
                end else if (w_poll_hit) begin
                    w_load      = 1'b1;
                end
                if (w_load)
                    w_state_n = ST_ISSUE;
            end
            ST_ISSUE:    w_state_n = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (w_match) begin
                    w_state_n = ST_IDLE;
                end else if (w_wait_last) begin
                    w_state_n = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            default:     w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_tag         <= '0;
            r_issue_data  <= '0;
            r_last_cmd    <= '0;
            r_counts      <= '0;
            r_prev_dir    <= '0;
            r_poll        <= '0;
            r_wait        <= '0;
            r_prev_ovf    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_tag     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_prev_ovf <= w_ovf;
            if (w_load) begin
                r_issue_data <= w_load_data;
                r_poll       <= '0;
            end else if (r_state == ST_IDLE) begin
                r_poll <= r_poll + 1'b1;
            end
            if (r_state == ST_ISSUE) begin
                r_last_cmd <= r_issue_data;
                r_prev_dir <= w_dir;
                r_wait     <= '0;
            end else if (r_state == ST_WAIT_RSP) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_match || w_timeout)
                r_tag <= next_tag(r_tag);
            if (w_timeout)
                r_err_timeout <= 1'b1;
            if (w_stray)
                r_err_tag <= 1'b1;
            if (w_match)
                r_counts <= bus.r_data;
        end
    end

    motor_odometer u_odo1 (
        .clk        (clk),
        .rst        (rst),
        .new_cnt    (bus.r_data[c_CNT_W-1:0]),
        .is_ovf     (w_ovf),
        .run_start  (!r_prev_ovf),
        .clear_last (w_match),
        .dir        (w_dir[0]),
        .update     (w_ovf || w_match),
        .odo        (odo1)
    );

    motor_odometer u_odo2 (
        .clk        (clk),
        .rst        (rst),
        .new_cnt    (bus.r_data[2*c_CNT_W-1:c_CNT_W]),
        .is_ovf     (w_ovf),
        .run_start  (!r_prev_ovf),
        .clear_last (w_match),
        .dir        (w_dir[1]),
        .update     (w_ovf || w_match),
        .odo        (odo2)
    );

    assign bus.cmd_ready = !rst && (r_state == ST_IDLE) && !estop;
    assign bus.m_wr      = (r_state == ST_ISSUE);
    assign bus.m_ctrl    = r_tag;
    assign bus.m_data    = r_issue_data;
    assign rsp_valid     = w_match;
    assign rsp_counts    = w_match ? bus.r_data : r_counts;
    assign err_timeout   = r_err_timeout;
    assign err_tag       = r_err_tag;
    assign busy          = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_motor_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_master
// Brief    : Randomized self-checking bench for motor_master against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_motor_master;
    localparam int POLL = 8;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        estop = 1'b0;
    logic [31:0] odo1, odo2;
    logic        rsp_valid, err_timeout, err_tag, busy;
    logic [23:0] rsp_counts;

    motor_master_if u_if ();

    motor_master #(.POLL_CYCLES(POLL), .TIMEOUT(TMO)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (u_if),
        .estop       (estop),
        .odo1        (odo1),
        .odo2        (odo2),
        .rsp_valid   (rsp_valid),
        .rsp_counts  (rsp_counts),
        .err_timeout (err_timeout),
        .err_tag     (err_tag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] md_odo [2];
    logic [11:0] md_last [2];
    logic [3:0]  md_tag;
    logic [23:0] md_cmd;
    logic [1:0]  md_prev_dir;
    logic        md_err_tag;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        md_odo[0] = '0; md_odo[1] = '0;
        md_last[0] = '0; md_last[1] = '0;
        md_tag = '0; md_cmd = '0; md_prev_dir = '0; md_err_tag = 1'b0;
    endtask

    task automatic adv_tag();
        md_tag = (md_tag == 4'd14) ? 4'd0 : md_tag + 4'd1;
    endtask

    // Apply one report to both channels: delta is the mod-4096 distance, or a full 4096 on a fresh FFF->FFF overflow.
    task automatic m_apply(input logic [23:0] d, input bit ovf, input bit run_start, input bit clr);
        for (int ch = 0; ch < 2; ch++) begin
            logic [11:0] nc;
            int          dl;
            nc = (ch == 0) ? d[11:0] : d[23:12];
            dl = (int'({20'd0, nc}) - int'({20'd0, md_last[ch]})) & 4095;
            if (ovf && run_start && nc == 12'hFFF && md_last[ch] == 12'hFFF)
                dl = 4096;
            md_odo[ch] = md_prev_dir[ch] ? md_odo[ch] + 32'(dl) : md_odo[ch] - 32'(dl);
            md_last[ch] = clr ? 12'd0 : nc;
        end
    endtask

    task automatic issue_wait(input logic [23:0] exp, input int maxc);
        int n = 0;
        while (u_if.m_wr !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        chk("issue_seen", 32'(u_if.m_wr), 32'd1);
        if (u_if.m_wr === 1'b1) begin
            chk("m_ctrl", 32'(u_if.m_ctrl), 32'(md_tag));
            chk("m_data", 32'(u_if.m_data), 32'(exp));
            md_prev_dir = {md_cmd[23], md_cmd[11]};
            md_cmd      = exp;
        end
    endtask

    // Entered during the ISSUE cycle; ends in the first IDLE cycle after the matched report.
    task automatic reply(input logic [23:0] counts, input int nf, input logic [23:0] fc, input bit stray);
        tick();
        for (int i = 0; i < nf; i++) begin
            u_if.r_wr = 1'b1; u_if.r_ctrl = 4'hF; u_if.r_data = fc;
            #1;
            chk("rsp_on_ovf", 32'(rsp_valid), 32'd0);
            m_apply(fc, 1'b1, i == 0, 1'b0);
            tick();
        end
        if (stray) begin
            logic [3:0] t;
            t = 4'($urandom_range(0, 14));
            if (t == md_tag) t = (md_tag == 4'd0) ? 4'd1 : 4'd0;
            u_if.r_wr = 1'b1; u_if.r_ctrl = t; u_if.r_data = 24'($urandom);
            #1;
            chk("rsp_on_stray", 32'(rsp_valid), 32'd0);
            md_err_tag = 1'b1;
            tick();
        end
        u_if.r_wr = 1'b1; u_if.r_ctrl = md_tag; u_if.r_data = counts;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_counts", 32'(rsp_counts), 32'(counts));
        tick();
        u_if.r_wr = 1'b0;
        m_apply(counts, 1'b0, 1'b0, 1'b1);
        adv_tag();
        chk("odo1", odo1, md_odo[0]);
        chk("odo2", odo2, md_odo[1]);
        chk("busy_after_rsp", 32'(busy), 32'd0);
        chk("err_tag", 32'(err_tag), 32'(md_err_tag));
    endtask

    task automatic do_cmd(input logic [23:0] d, input logic [23:0] counts, input int nf,
                          input logic [23:0] fc, input bit stray);
        u_if.cmd_valid = 1'b1; u_if.cmd_data = d;
        #1;
        chk("cmd_ready", 32'(u_if.cmd_ready), 32'd1);
        tick();
        u_if.cmd_valid = 1'b0;
        issue_wait(d, 0);
        reply(counts, nf, fc, stray);
    endtask

    task automatic f_run(input logic [23:0] fc, input int len);
        for (int i = 0; i < len; i++) begin
            u_if.r_wr = 1'b1; u_if.r_ctrl = 4'hF; u_if.r_data = fc;
            m_apply(fc, 1'b1, i == 0, 1'b0);
            tick();
        end
        u_if.r_wr = 1'b0;
        chk("f_odo1", odo1, md_odo[0]);
        chk("f_odo2", odo2, md_odo[1]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d, old_tag;
        int          n;
        u_if.cmd_valid = 1'b0; u_if.cmd_data = '0;
        u_if.r_wr = 1'b0; u_if.r_ctrl = '0; u_if.r_data = '0;
        model_reset();

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", 32'(u_if.cmd_ready), 32'd0);
        chk("rst_m_wr", 32'(u_if.m_wr), 32'd0);
        chk("rst_m_ctrl", 32'(u_if.m_ctrl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_odo1", odo1, 32'd0);
        chk("rst_odo2", odo2, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_err_tag", 32'(err_tag), 32'd0);
        rst = 1'b0;

        // Directed: direction comes from the command in force before the issue
        do_cmd(24'h800000, 24'h000000, 0, 24'h0, 1'b0);
        do_cmd(24'h800400, 24'h00A005, 0, 24'h0, 1'b0);
        chk("t1_odo1", odo1, 32'hFFFF_FFFB);
        chk("t1_odo2", odo2, 32'd10);

        // Overflow runs: one run counted once, then a fresh FFF run counts a full wrap
        do_cmd(24'h000000, 24'h000010, 3, 24'h000FFF, 1'b0);
        f_run(24'h000FFF, 3);
        tick();
        f_run(24'h000FFF, 1);

        // Estop overrides a pending command and repeats while held
        u_if.cmd_valid = 1'b1; u_if.cmd_data = 24'h7FF3FF; estop = 1'b1;
        #1;
        chk("estop_cmd_ready", 32'(u_if.cmd_ready), 32'd0);
        tick();
        issue_wait(md_cmd & 24'h800800, 0);
        reply(24'h003002, 0, 24'h0, 1'b0);
        chk("estop_hold_ready", 32'(u_if.cmd_ready), 32'd0);
        tick();
        issue_wait(md_cmd & 24'h800800, 0);
        estop = 1'b0;
        reply(24'h001001, 0, 24'h0, 1'b0);
        tick();
        u_if.cmd_valid = 1'b0;
        issue_wait(24'h7FF3FF, 0);
        reply(24'h123456, 0, 24'h0, 1'b0);

        // Timeout when the motor block stays silent
        d = 24'($urandom);
        u_if.cmd_valid = 1'b1; u_if.cmd_data = d;
        tick();
        u_if.cmd_valid = 1'b0;
        issue_wait(d, 0);
        n = 0;
        while (busy && n < 4 * TMO) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO + 1));
        chk("err_timeout", 32'(err_timeout), 32'd1);
        adv_tag();

        // Stray tag while waiting, then the right tag still completes
        do_cmd(24'($urandom), 24'($urandom), 0, 24'h0, 1'b1);

        // Keep-alive poll re-issues the last command after POLL idle cycles
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (u_if.m_wr !== 1'b1 && n < 3 * POLL) begin
                tick();
                n++;
            end
            chk("poll_gap", 32'(n), 32'(POLL));
            issue_wait(md_cmd, 0);
            reply(24'($urandom), 0, 24'h0, 1'b0);
        end

        // Randomized traffic; enough commands to wrap the tag sequence
        for (int k = 0; k < 18; k++) begin
            do_cmd(24'($urandom), 24'($urandom), int'($urandom_range(0, 3)), 24'($urandom),
                   $urandom_range(0, 3) == 0);
        end

        // Reset while waiting; the late report carries a stale tag
        d = 24'($urandom);
        u_if.cmd_valid = 1'b1; u_if.cmd_data = d;
        tick();
        u_if.cmd_valid = 1'b0;
        issue_wait(d, 0);
        old_tag = 24'(md_tag);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_err_tag", 32'(err_tag), 32'd0);
        chk("rst2_err_timeout", 32'(err_timeout), 32'd0);
        u_if.r_wr = 1'b1; u_if.r_ctrl = old_tag[3:0]; u_if.r_data = 24'h00F00F;
        #1;
        chk("late_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        u_if.r_wr = 1'b0;
        chk("late_err_tag", 32'(err_tag), 32'd1);
        chk("late_odo1", odo1, 32'd0);
        chk("late_odo2", odo2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
